// File: rtl/alu_mc.sv
// Registered ARM data-processing ALU with an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to build the MUL/MLA multiplier; without it, multiply requests finish in one cycle and write nothing back.
module alu_mc #(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             in_Clk,
    input  logic             in_Rst,
    input  logic             in_Start,
    input  logic             in_Mul,
    input  logic             in_Accum,
    input  logic [3:0]       in_Opcode,
    input  logic [WIDTH-1:0] in_Rn,
    input  logic [WIDTH-1:0] in_Op2,
    input  logic [WIDTH-1:0] in_Rs,
    input  logic [WIDTH-1:0] in_Acc,
    input  logic             in_Carry,
    input  logic [3:0]       in_CNZV,
    output logic             out_Busy,
    output logic             out_Done,
    output logic [WIDTH-1:0] out_Y,
    output logic [3:0]       out_CNZV,
    output logic             out_WrEn
);

    logic [WIDTH-1:0] a_op, b_op, dp_y;
    logic             cin, is_arith, dp_c, dp_v, dp_wr_en;
    logic [WIDTH:0]   sum;
    logic [3:0]       dp_cnzv;

    logic [WIDTH-1:0] y_q;
    logic [3:0]       cnzv_q;
    logic             wr_en_q, done_q, accept;

    // Every arithmetic opcode folds into one adder: A + B + cin.
    always_comb begin
        a_op     = in_Rn;
        b_op     = in_Op2;
        cin      = 1'b0;
        is_arith = 1'b1;
        case (in_Opcode)
            4'h2, 4'hA: begin b_op = ~in_Op2; cin = 1'b1;       end
            4'h3:       begin a_op = in_Op2; b_op = ~in_Rn; cin = 1'b1; end
            4'h4, 4'hB: cin = 1'b0;
            4'h5:       cin = in_CNZV[3];
            4'h6:       begin b_op = ~in_Op2; cin = in_CNZV[3]; end
            4'h7:       begin a_op = in_Op2; b_op = ~in_Rn; cin = in_CNZV[3]; end
            default:    is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        dp_y = sum[WIDTH-1:0];
        case (in_Opcode)
            4'h0, 4'h8: dp_y = in_Rn & in_Op2;
            4'h1, 4'h9: dp_y = in_Rn ^ in_Op2;
            4'hC:       dp_y = in_Rn | in_Op2;
            4'hD:       dp_y = in_Op2;
            4'hE:       dp_y = in_Rn & ~in_Op2;
            4'hF:       dp_y = ~in_Op2;
            default:    dp_y = sum[WIDTH-1:0];
        endcase
    end

    assign dp_c     = is_arith ? sum[WIDTH] : in_Carry;
    assign dp_v     = is_arith ? ((a_op[WIDTH-1] == b_op[WIDTH-1]) && (dp_y[WIDTH-1] != a_op[WIDTH-1]))
                               : in_CNZV[0];
    assign dp_cnzv  = {dp_c, dp_y[WIDTH-1], (dp_y == '0), dp_v};
    // Opcodes 8..B are the compare/test group: flags only.
    assign dp_wr_en = (in_Opcode[3:2] != 2'b10);

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]     mcand, mplr, acc, acc_step;
    logic [MUL_CNT_W-1:0] cnt;
    logic [1:0]           cv_hold;

    assign accept   = in_Start && (state == S_IDLE);
    assign acc_step = acc + (mplr[0] ? mcand : '0);
    assign out_Busy = (state == S_MUL);

    always_ff @(posedge in_Clk) begin
        if (in_Rst) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_Start && in_Mul) state_next = S_MUL;
            S_MUL:   if (cnt == MUL_CNT_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end
`else
    assign accept   = in_Start;
    assign out_Busy = 1'b0;
    wire [MUL_CNT_W-1:0] unused_cnt_w = '0;
    wire unused_mul_in = &{1'b0, in_Accum, in_Rs, in_Acc, unused_cnt_w};
`endif

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            y_q     <= '0;
            cnzv_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MUL_EN
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            cv_hold <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept && !in_Mul) begin
                y_q     <= dp_y;
                cnzv_q  <= dp_cnzv;
                wr_en_q <= dp_wr_en;
                done_q  <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (accept && in_Mul) begin
                mcand   <= in_Rn;
                mplr    <= in_Rs;
                acc     <= in_Accum ? in_Acc : '0;
                cnt     <= MUL_CNT_W'(WIDTH);
                cv_hold <= {in_CNZV[3], in_CNZV[0]};
            end
            if (state == S_MUL) begin
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                acc   <= acc_step;
                cnt   <= cnt - MUL_CNT_W'(1);
                // Last iteration: the final partial product goes straight to the result.
                if (cnt == MUL_CNT_W'(1)) begin
                    y_q     <= acc_step;
                    cnzv_q  <= {cv_hold[1], acc_step[WIDTH-1], (acc_step == '0), cv_hold[0]};
                    wr_en_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            end
`else
            else if (accept && in_Mul) begin
                y_q     <= '0;
                cnzv_q  <= in_CNZV;
                wr_en_q <= 1'b0;
                done_q  <= 1'b1;
            end
`endif
        end
    end

    assign out_Y    = y_q;
    assign out_CNZV = cnzv_q;
    assign out_WrEn = wr_en_q;
    assign out_Done = done_q;

endmodule
